// File: rtl/baud_gen_frac_if.sv
// Control and tick bundle between a UART FSM pair and its baud_gen_frac.
// The master side programs the divisor and gates the generator; the slave
// side (the generator itself) returns the tick pulses and the load-error flag.
interface baud_gen_frac_if #(
    parameter int DIV_W     = 16,
    parameter int FRAC_BITS = 4
) ();
    logic                 en;
    logic                 restart;
    logic                 div_load;
    logic [DIV_W-1:0]     div_int;
    logic [FRAC_BITS-1:0] div_frac;
    logic                 sample_tick;
    logic                 mid_tick;
    logic                 bit_tick;
    logic                 div_err;

    modport master (
        output en, restart, div_load, div_int, div_frac,
        input  sample_tick, mid_tick, bit_tick, div_err
    );

    modport slave (
        input  en, restart, div_load, div_int, div_frac,
        output sample_tick, mid_tick, bit_tick, div_err
    );
endinterface

// File: rtl/baud_gen_frac.sv
// Fractional UART baud-tick generator.
// A period counter runs for act_int (+1 when the fractional accumulator
// carries) clocks per sample tick, so the long-run sample period equals
// act_int + act_frac/2^FRAC_BITS clocks with no drift. A sub-bit counter
// derives the mid-bit and end-of-bit ticks from the sample ticks. New
// divisors are staged in a shadow register and only take effect at a period
// boundary (or immediately while frozen / on restart) so a tick period is
// never cut short.
module baud_gen_frac #(
    parameter int unsigned CLK_FREQ     = 100_000_000,
    parameter int unsigned DEFAULT_BAUD = 9600,
    parameter int unsigned OVERSAMPLE   = 8,
    parameter int          DIV_W        = 16,
    parameter int          FRAC_BITS    = 4
) (
    input  logic             clk,
    input  logic             rst,
    baud_gen_frac_if.slave   bus
);

    localparam int SUB_W = $clog2(OVERSAMPLE);

    // Reset divisor in 1/2^FRAC_BITS clock units, truncated.
    localparam logic [63:0] DEF_DIV =
        (64'(CLK_FREQ) * (64'd1 << FRAC_BITS)) / (64'(DEFAULT_BAUD) * 64'(OVERSAMPLE));
    localparam logic [DIV_W-1:0]     DEF_INT  = DIV_W'(DEF_DIV >> FRAC_BITS);
    localparam logic [FRAC_BITS-1:0] DEF_FRAC = FRAC_BITS'(DEF_DIV);

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
    localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(OVERSAMPLE / 2 - 1);

    // State registers
    logic [DIV_W-1:0]     cnt_r;
    logic [FRAC_BITS-1:0] acc_r;
    logic                 carry_r;
    logic [SUB_W-1:0]     sub_r;
    logic [DIV_W-1:0]     act_int_r;
    logic [FRAC_BITS-1:0] act_frac_r;
    logic [DIV_W-1:0]     pend_int_r;
    logic [FRAC_BITS-1:0] pend_frac_r;
    logic                 pend_vld_r;
    logic                 sample_tick_r;
    logic                 mid_tick_r;
    logic                 bit_tick_r;
    logic                 div_err_r;

    // Next-state values
    logic [DIV_W-1:0]     cnt_s;
    logic [FRAC_BITS-1:0] acc_s;
    logic                 carry_s;
    logic [SUB_W-1:0]     sub_s;
    logic [DIV_W-1:0]     act_int_s;
    logic [FRAC_BITS-1:0] act_frac_s;
    logic [DIV_W-1:0]     pend_int_s;
    logic [FRAC_BITS-1:0] pend_frac_s;
    logic                 pend_vld_s;
    logic                 sample_tick_s;
    logic                 mid_tick_s;
    logic                 bit_tick_s;
    logic                 div_err_s;

    // Helpers
    logic [DIV_W:0]       period_last_s;
    logic                 term_s;
    logic                 apply_s;
    logic [FRAC_BITS:0]   acc_sum_s;

    // Terminal detection: period length is act_int plus the pending carry.
    always_comb begin
        period_last_s = {1'b0, act_int_r} + {{DIV_W{1'b0}}, carry_r} - (DIV_W+1)'(1);
        term_s        = bus.en && ({1'b0, cnt_r} == period_last_s);
        acc_sum_s     = {1'b0, acc_r} + {1'b0, act_frac_r};
    end

    // Next-state logic for counters, ticks, divisor shadowing and load checks.
    always_comb begin
        cnt_s         = cnt_r;
        acc_s         = acc_r;
        carry_s       = carry_r;
        sub_s         = sub_r;
        act_int_s     = act_int_r;
        act_frac_s    = act_frac_r;
        pend_int_s    = pend_int_r;
        pend_frac_s   = pend_frac_r;
        pend_vld_s    = pend_vld_r;
        sample_tick_s = 1'b0;
        mid_tick_s    = 1'b0;
        bit_tick_s    = 1'b0;
        div_err_s     = 1'b0;
        apply_s       = 1'b0;

        if (bus.restart) begin
            // Realign phase; a terminal count on this edge is swallowed.
            cnt_s   = '0;
            acc_s   = '0;
            carry_s = 1'b0;
            sub_s   = '0;
            apply_s = pend_vld_r;
        end else if (!bus.en) begin
            // Frozen: hold phase, but a staged divisor can go live now.
            apply_s = pend_vld_r;
        end else if (term_s) begin
            cnt_s         = '0;
            {carry_s, acc_s} = acc_sum_s;
            sample_tick_s = 1'b1;
            sub_s         = (sub_r == SUB_LAST) ? '0 : sub_r + SUB_W'(1);
            bit_tick_s    = (sub_r == SUB_LAST);
            mid_tick_s    = (sub_r == SUB_MID);
            apply_s       = pend_vld_r;
        end else begin
            cnt_s   = cnt_r + DIV_W'(1);
            apply_s = 1'b0;
        end

        if (apply_s) begin
            act_int_s  = pend_int_r;
            act_frac_s = pend_frac_r;
            pend_vld_s = 1'b0;
        end else begin
            act_int_s  = act_int_r;
            act_frac_s = act_frac_r;
        end

        // A fresh load overrides both the old shadow and its just-cleared flag.
        if (bus.div_load) begin
            if (bus.div_int >= DIV_W'(2)) begin
                pend_int_s  = bus.div_int;
                pend_frac_s = bus.div_frac;
                pend_vld_s  = 1'b1;
            end else begin
                div_err_s = 1'b1;
            end
        end else begin
            div_err_s = 1'b0;
        end
    end

    // State and registered-output update with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r         <= '0;
            acc_r         <= '0;
            carry_r       <= 1'b0;
            sub_r         <= '0;
            act_int_r     <= DEF_INT;
            act_frac_r    <= DEF_FRAC;
            pend_int_r    <= DEF_INT;
            pend_frac_r   <= DEF_FRAC;
            pend_vld_r    <= 1'b0;
            sample_tick_r <= 1'b0;
            mid_tick_r    <= 1'b0;
            bit_tick_r    <= 1'b0;
            div_err_r     <= 1'b0;
        end else begin
            cnt_r         <= cnt_s;
            acc_r         <= acc_s;
            carry_r       <= carry_s;
            sub_r         <= sub_s;
            act_int_r     <= act_int_s;
            act_frac_r    <= act_frac_s;
            pend_int_r    <= pend_int_s;
            pend_frac_r   <= pend_frac_s;
            pend_vld_r    <= pend_vld_s;
            sample_tick_r <= sample_tick_s;
            mid_tick_r    <= mid_tick_s;
            bit_tick_r    <= bit_tick_s;
            div_err_r     <= div_err_s;
        end
    end

    assign bus.sample_tick = sample_tick_r;
    assign bus.mid_tick    = mid_tick_r;
    assign bus.bit_tick    = bit_tick_r;
    assign bus.div_err     = div_err_r;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: a per-cycle vector table for the
// integer-divisor, load and error behaviour, plus hand-written sequences for
// the default rate, fractional spacing, restart, enable and reset cases.
module tb_baud_gen_frac;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    baud_gen_frac_if #(.DIV_W(16), .FRAC_BITS(4)) bus ();

    baud_gen_frac #(
        .CLK_FREQ    (100_000_000),
        .DEFAULT_BAUD(9600),
        .OVERSAMPLE  (8),
        .DIV_W       (16),
        .FRAC_BITS   (4)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        restart;
        logic        div_load;
        logic [15:0] div_int;
        logic [3:0]  div_frac;
        logic [3:0]  exp;      // {sample, mid, bit, err}
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic en, input logic rs, input logic ld,
                                    input logic [15:0] di, input logic [3:0] df,
                                    input logic [3:0] ex);
        vec_t v;
        v.en = en; v.restart = rs; v.div_load = ld;
        v.div_int = di; v.div_frac = df; v.exp = ex;
        vecs.push_back(v);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Clock edges until the next sample_tick, bounded by limit.
    task automatic wait_tick(input int limit, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!bus.sample_tick && n < limit);
        if (!bus.sample_tick) begin
            checks++;
            errors++;
            $display("FAIL wait_tick: no sample_tick within %0d clks", limit);
        end
    endtask

    function automatic int outs();
        return {28'd0, bus.sample_tick, bus.mid_tick, bus.bit_tick, bus.div_err};
    endfunction

    initial begin
        int n;
        int span;
        int k;
        logic st;
        logic [3:0] ex;
        logic seen;

        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.en = 1'b0;
        bus.restart = 1'b0;
        bus.div_load = 1'b0;
        bus.div_int = 16'd0;
        bus.div_frac = 4'd0;

        // ---------------- reset state ----------------
        repeat (3) cyc();
        check("reset_outputs", outs(), 0);

        // ---------------- defaults: 1302 + 1/16 ----------------
        rst = 1'b1;
        bus.en = 1'b1;
        wait_tick(1400, n);
        check("default_first_period", n, 1302);
        span = 0;
        for (int t = 2; t <= 21; t++) begin
            wait_tick(1400, n);
            span += n;
            if (t == 4)  check("default_mid_on_tick4", int'(bus.mid_tick), 1);
            if (t == 8)  check("default_bit_on_tick8", int'(bus.bit_tick), 1);
            if (t == 16) check("default_period16", n, 1302);
            if (t == 17) check("default_carry_period", n, 1303);
        end
        // 20 periods of 1302 with one carry (after tick 16)
        check("default_span20", span, 26041);

        // ---------------- vector table: int=4, error load, 4->6 change ----------------
        add_vec(1'b0, 1'b0, 1'b1, 16'd4, 4'd0, 4'b0000);
        add_vec(1'b0, 1'b1, 1'b0, 16'd0, 4'd0, 4'b0000);
        for (int e = 1; e <= 94; e++) begin
            logic ld;
            logic [15:0] di;
            ld = 1'b0;
            di = 16'd0;
            if (e == 41) begin ld = 1'b1; di = 16'd1; end
            if (e == 50) begin ld = 1'b1; di = 16'd6; end
            if (e <= 52) begin
                st = (e % 4 == 0);
                k  = e / 4;
            end else begin
                st = ((e - 52) % 6 == 0);
                k  = 13 + (e - 52) / 6;
            end
            ex = {st, st && (k % 8 == 4), st && (k % 8 == 0), (e == 41)};
            add_vec(1'b1, 1'b0, ld, di, 4'd0, ex);
        end
        foreach (vecs[i]) begin
            bus.en       = vecs[i].en;
            bus.restart  = vecs[i].restart;
            bus.div_load = vecs[i].div_load;
            bus.div_int  = vecs[i].div_int;
            bus.div_frac = vecs[i].div_frac;
            cyc();
            checks++;
            if (outs() != int'(vecs[i].exp)) begin
                errors++;
                $display("FAIL vec[%0d]: got {s,m,b,e}=%b, expected %b",
                         i, outs() & 4'hF, vecs[i].exp);
            end
        end
        bus.div_load = 1'b0;
        bus.div_int  = 16'd0;

        // ---------------- int=4 frac=8: 4,4,5,4,5... ----------------
        bus.div_load = 1'b1; bus.div_int = 16'd4; bus.div_frac = 4'd8;
        cyc();
        bus.div_load = 1'b0; bus.restart = 1'b1;
        cyc();
        bus.restart = 1'b0;
        wait_tick(20, n);
        check("frac_first_period", n, 4);
        span = 0;
        for (int j = 1; j <= 200; j++) begin
            wait_tick(20, n);
            span += n;
            if (j == 1) check("frac_period1", n, 4);
            if (j == 2) check("frac_period2", n, 5);
        end
        check("frac_span200", span, 900);

        // ---------------- restart at cnt=2 ----------------
        bus.div_load = 1'b1; bus.div_int = 16'd4; bus.div_frac = 4'd0;
        cyc();
        bus.div_load = 1'b0; bus.restart = 1'b1;
        cyc();
        bus.restart = 1'b0;
        repeat (2) cyc();
        bus.restart = 1'b1;
        cyc();
        bus.restart = 1'b0;
        check("restart_no_tick", int'(bus.sample_tick), 0);
        wait_tick(20, n);
        check("restart_next_period", n, 4);
        check("restart_tick1_not_mid", int'(bus.mid_tick), 0);
        wait_tick(20, n);
        wait_tick(20, n);
        wait_tick(20, n);
        check("restart_mid_on_tick4", int'(bus.mid_tick), 1);

        // ---------------- restart coincident with terminal ----------------
        repeat (3) cyc();
        bus.restart = 1'b1;
        cyc();
        bus.restart = 1'b0;
        check("restart_at_terminal_no_tick", int'(bus.sample_tick), 0);
        wait_tick(20, n);
        check("restart_at_terminal_period", n, 4);

        // ---------------- en low for 10 clocks mid-period ----------------
        repeat (2) cyc();
        bus.en = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (bus.sample_tick) seen = 1'b1;
        end
        check("en_low_no_ticks", int'(seen), 0);
        bus.en = 1'b1;
        wait_tick(40, n);
        check("en_low_delay_total", 2 + 10 + n, 14);

        // ---------------- async reset mid-period ----------------
        rst = 1'b0;
        #1;
        check("async_reset_clears_tick", outs(), 0);
        repeat (3) cyc();
        check("reset_held_outputs", outs(), 0);
        rst = 1'b1;
        wait_tick(1400, n);
        check("after_reset_default_period", n, 1302);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
